// File: rtl/div_pkg.sv
// Shared definitions for the integer divide unit.
// Holds f3 encodings, the divide fu_sel code and the FSM state type.
package div_pkg;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [2:0] FU_DIV = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_unit_core.sv
// Radix-2 restoring divide datapath on unsigned 32-bit magnitudes.
// Ports: clk, rst, load/step controls, dividend/divisor in, quo/rem out.
module div_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [32:0] shifted;
    logic [32:0] diff;

    // 33-bit partial remainder: the stored remainder is always below the
    // divisor, so shifting in the next dividend bit needs one extra bit.
    // diff[32] set means the trial subtraction borrowed.
    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            if (!diff[32]) begin
                rem_q <= diff[31:0];
                quo_q <= {quo_q[30:0], 1'b1};
            end else begin
                rem_q <= shifted[31:0];
                quo_q <= {quo_q[30:0], 1'b0};
            end
        end
    end

    assign quo = quo_q;
    assign rem = rem_q;

endmodule

// File: rtl/div_unit.sv
// Divide functional unit: FSM, sign handling, flush and result select.
// Ports: clk, rst, in_* op from RR, ready, out_* toward writeback,
// out_ready, mispredict/flush_mask. Option macro: DIV_EARLY_OUT_EN.
module div_unit
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    input  logic [2:0]  in_f3,
    input  logic [6:0]  in_rd,
    input  logic [2:0]  in_rob_idx,
    output logic        ready,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic [6:0]  out_rd,
    output logic [2:0]  out_rob_idx,
    input  logic        out_ready,
    input  logic        mispredict,
    input  logic [7:0]  flush_mask
);

    div_state_t  state;
    logic [4:0]  cnt;
    logic [31:0] a_mag;
    logic        neg_q;
    logic        neg_r;
    logic        is_rem;
    logic        div0;
    logic        ovf;
    logic [6:0]  rd_q;
    logic [2:0]  rob_q;

    logic        in_signed;
    logic        in_rem;
    logic        in_div0;
    logic        in_ovf;
    logic [31:0] in_a_mag;
    logic [31:0] in_b_mag;
    logic        early;
    logic        accept;
    logic        kill;
    logic [31:0] core_quo;
    logic [31:0] core_rem;
    logic [31:0] rs1_val;
    logic [31:0] q_res;
    logic [31:0] r_res;

    assign in_signed = (in_f3 == F3_DIV) || (in_f3 == F3_REM);
    assign in_rem    = (in_f3 == F3_REM) || (in_f3 == F3_REMU);
    assign in_a_mag  = (in_signed && in_rs1_data[31]) ? -in_rs1_data : in_rs1_data;
    assign in_b_mag  = (in_signed && in_rs2_data[31]) ? -in_rs2_data : in_rs2_data;
    assign in_div0   = (in_rs2_data == '0);
    assign in_ovf    = in_signed
                    && (in_rs1_data == 32'h8000_0000)
                    && (in_rs2_data == 32'hFFFF_FFFF);

`ifdef DIV_EARLY_OUT_EN
    logic small;
    logic in_small;
    assign in_small = (in_a_mag < in_b_mag);
    assign early    = in_div0 || in_ovf || in_small;
`else
    assign early = 1'b0;
`endif

    assign ready  = (state == IDLE);
    assign accept = in_valid && ready && !(mispredict && flush_mask[in_rob_idx]);
    assign kill   = mispredict && flush_mask[rob_q];

    div_core u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .step     (state == CALC),
        .dividend (in_a_mag),
        .divisor  (in_b_mag),
        .quo      (core_quo),
        .rem      (core_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_mag  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_rem <= 1'b0;
            div0   <= 1'b0;
            ovf    <= 1'b0;
            rd_q   <= '0;
            rob_q  <= '0;
`ifdef DIV_EARLY_OUT_EN
            small  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        a_mag  <= in_a_mag;
                        neg_q  <= in_signed && (in_rs1_data[31] ^ in_rs2_data[31]);
                        neg_r  <= in_signed && in_rs1_data[31];
                        is_rem <= in_rem;
                        div0   <= in_div0;
                        ovf    <= in_ovf;
                        rd_q   <= in_rd;
                        rob_q  <= in_rob_idx;
                        cnt    <= 5'd31;
`ifdef DIV_EARLY_OUT_EN
                        small  <= in_small;
`endif
                        state  <= early ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (kill) begin
                        state <= IDLE;
                    end else if (cnt == 5'd0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                DONE: begin
                    if (kill || out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Original rs1 rebuilt from its magnitude; it is the remainder
    // whenever the quotient is zero or the divisor is zero.
    assign rs1_val = neg_r ? -a_mag : a_mag;

    always_comb begin
        q_res = neg_q ? -core_quo : core_quo;
        r_res = neg_r ? -core_rem : core_rem;
        if (div0) begin
            q_res = 32'hFFFF_FFFF;
            r_res = rs1_val;
        end else if (ovf) begin
            q_res = 32'h8000_0000;
            r_res = '0;
        end
`ifdef DIV_EARLY_OUT_EN
        else if (small) begin
            q_res = '0;
            r_res = rs1_val;
        end
`endif
    end

    assign out_valid   = (state == DONE);
    assign out_data    = (state == DONE) ? (is_rem ? r_res : q_res) : '0;
    assign out_rd      = rd_q;
    assign out_rob_idx = rob_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, random ops vs a
// plain-arithmetic model, and hand sequences for flush/stall/reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [2:0]  in_f3;
    logic [6:0]  in_rd;
    logic [2:0]  in_rob_idx;
    logic        ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [6:0]  out_rd;
    logic [2:0]  out_rob_idx;
    logic        out_ready;
    logic        mispredict;
    logic [7:0]  flush_mask;

    always #5 clk = ~clk;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .in_f3       (in_f3),
        .in_rd       (in_rd),
        .in_rob_idx  (in_rob_idx),
        .ready       (ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_rd      (out_rd),
        .out_rob_idx (out_rob_idx),
        .out_ready   (out_ready),
        .mispredict  (mispredict),
        .flush_mask  (flush_mask)
    );

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        bit sgn;
        bit rem;
        sa  = int'(a);
        sb  = int'(b);
        sgn = (f3 == 3'b100) || (f3 == 3'b110);
        rem = f3[1];
        if (b == 0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return rem ? 32'h0 : 32'h8000_0000;
        if (sgn) return rem ? 32'(sa % sb) : 32'(sa / sb);
        return rem ? a % b : a / b;
    endfunction

    // Sample index (one per falling edge, acceptance cycle = 0) at which
    // out_valid is first seen.
    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
        longint la;
        longint lb;
        bit sgn;
        bit e;
        sgn = (f3 == 3'b100) || (f3 == 3'b110);
        la  = sgn ? longint'(int'(a)) : longint'(a);
        lb  = sgn ? longint'(int'(b)) : longint'(b);
        if (la < 0) la = -la;
        if (lb < 0) lb = -lb;
        e = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (la < lb);
        return (EARLY && e) ? 1 : 33;
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [6:0] rd, input logic [2:0] rob);
        in_valid    = 1'b1;
        in_f3       = f3;
        in_rs1_data = a;
        in_rs2_data = b;
        in_rd       = rd;
        in_rob_idx  = rob;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input logic [6:0] rd, input logic [2:0] rob);
        int lat;
        @(negedge clk);
        chk({name, " ready"}, 32'(ready), 32'd1);
        issue(f3, a, b, rd, rob);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, lat, exp_lat(f3, a, b));
        chk({name, " data"}, out_data, exp);
        chk({name, " rd"}, 32'(out_rd), 32'(rd));
        chk({name, " rob"}, 32'(out_rob_idx), 32'(rob));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, " back idle"}, {30'b0, ready, out_valid}, 32'b10);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[19];

    initial begin
        int seen;
        int lat;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;

        tbl[0]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD};
        tbl[1]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF};
        tbl[2]  = '{3'b111, 32'd7,         32'd0,        32'd7};
        tbl[3]  = '{3'b101, 32'd7,         32'd0,        32'hFFFF_FFFF};
        tbl[4]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        tbl[5]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        tbl[6]  = '{3'b100, 32'd5,         32'd0,        32'hFFFF_FFFF};
        tbl[7]  = '{3'b110, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB};
        tbl[8]  = '{3'b101, 32'd100,       32'd7,        32'd14};
        tbl[9]  = '{3'b111, 32'd100,       32'd7,        32'd2};
        tbl[10] = '{3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD};
        tbl[11] = '{3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1};
        tbl[12] = '{3'b101, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF};
        tbl[13] = '{3'b111, 32'd3,         32'd5,        32'd3};
        tbl[14] = '{3'b100, 32'hFFFF_FFFD, 32'd5,        32'd0};
        tbl[15] = '{3'b110, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFD};
        tbl[16] = '{3'b100, 32'h8000_0000, 32'd1,        32'h8000_0000};
        tbl[17] = '{3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        tbl[18] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_rs1_data = '0;
        in_rs2_data = '0;
        in_f3 = 3'b100;
        in_rd = '0;
        in_rob_idx = '0;
        out_ready = 1'b0;
        mispredict = 1'b0;
        flush_mask = '0;

        #1;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", out_data, 32'd0);
        chk("reset out_rd", 32'(out_rd), 32'd0);
        chk("reset out_rob", 32'(out_rob_idx), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].exp,
                   7'(i + 1), 3'(i));
        end

        for (int i = 0; i < 40; i++) begin
            rf3 = 3'(4 + $urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 5))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 20));
                2: rb = 32'hFFFF_FFFF;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), rf3, ra, rb, ref_res(rf3, ra, rb),
                   7'($urandom), 3'($urandom));
        end

        // flush of the in-flight op at CALC cycle 10
        @(negedge clk);
        issue(3'b100, 32'd1000, 32'd3, 7'd9, 3'd5);
        repeat (9) @(negedge clk);
        chk("flush pre busy", {30'b0, ready, out_valid}, 32'b00);
        mispredict = 1'b1;
        flush_mask = 8'h20;
        @(negedge clk);
        mispredict = 1'b0;
        flush_mask = 8'h00;
        chk("flush idle", {30'b0, ready, out_valid}, 32'b10);
        run_op("after flush", 3'b100, 32'd1000, 32'd3, 32'd333, 7'd9, 3'd5);

        // mispredict not covering the held rob_idx leaves the op alone
        @(negedge clk);
        issue(3'b101, 32'd1000, 32'd3, 7'd4, 3'd5);
        repeat (4) @(negedge clk);
        mispredict = 1'b1;
        flush_mask = 8'hDF;
        @(negedge clk);
        mispredict = 1'b0;
        flush_mask = 8'h00;
        lat = 6;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("other flush latency", lat, 33);
        chk("other flush data", out_data, 32'd333);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // flushed op at the input is never accepted
        in_valid = 1'b1;
        in_rob_idx = 3'd3;
        in_rs1_data = 32'd50;
        in_rs2_data = 32'd5;
        mispredict = 1'b1;
        flush_mask = 8'h08;
        @(negedge clk);
        in_valid = 1'b0;
        mispredict = 1'b0;
        flush_mask = 8'h00;
        chk("flushed input idle", 32'(ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("flushed input no result", seen, 0);

        // DONE held while writeback stalls
        issue(3'b101, 32'd100, 32'd7, 7'd12, 3'd2);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("hold latency", lat, exp_lat(3'b101, 32'd100, 32'd7));
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("hold data %0d", k), out_data, 32'd14);
            chk($sformatf("hold state %0d", k), {30'b0, ready, out_valid}, 32'b01);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold release", {30'b0, ready, out_valid}, 32'b10);

        // asynchronous reset mid-CALC
        issue(3'b101, 32'hFFFF_FFFF, 32'd3, 7'h55, 3'd6);
        repeat (4) @(negedge clk);
        chk("pre reset busy", 32'(ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async ready", 32'(ready), 32'd1);
        chk("async out_valid", 32'(out_valid), 32'd0);
        chk("async out_data", out_data, 32'd0);
        chk("async out_rd", 32'(out_rd), 32'd0);
        chk("async out_rob", 32'(out_rob_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("after reset rd0", 3'b101, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 7'd0, 3'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, the RR stage presents an op for fu_sel 2.
REQ-004 SHALL have ports in_rs1_data and in_rs2_data, input, 32 each: dividend and divisor.
REQ-005 SHALL have port in_f3, input, 3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports in_rd (input, 7, physical dest) and in_rob_idx (input, 3).
REQ-007 SHALL have port ready, output, 1; it drives EX_ready[2] to the RR stage.
REQ-008 SHALL have ports out_valid (output, 1), out_data (output, 32), out_rd (output, 7), out_rob_idx (output, 3) toward the writeback arbiter.
REQ-009 SHALL have port out_ready, input, 1, the writeback arbiter accepts the result.
REQ-010 SHALL have ports mispredict (input, 1) and flush_mask (input, 8, one bit per ROB index).

Function
REQ-011 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE.
REQ-012 ready SHALL be 1 only in IDLE (combinational from state).
REQ-013 An op SHALL be accepted when in_valid && ready && !(mispredict && flush_mask[in_rob_idx]); a flushed op is never accepted.
REQ-014 On acceptance the unit SHALL latch magnitudes, sign flags, f3, rd and rob_idx, set counter = 31 and enter CALC.
REQ-015 CALC SHALL perform one radix-2 restoring step per cycle on 32-bit magnitudes (33-bit partial remainder) and enter DONE after the step at counter 0, i.e. 32 cycles.
REQ-016 out_valid SHALL be 1 exactly in DONE; with no early-out, out_valid first rises 33 cycles after the acceptance edge.
REQ-017 DONE SHALL hold out_data, out_rd and out_rob_idx stable until out_ready; on the out_valid && out_ready edge the unit SHALL return to IDLE.
REQ-018 Signed ops: quotient sign = sign(rs1) ^ sign(rs2); remainder sign = sign(rs1); the result SHALL be converted back to two's complement in DONE.
REQ-019 Divide by zero SHALL give quotient 0xFFFFFFFF (DIV and DIVU) and remainder = rs1.
REQ-020 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-021 If mispredict && flush_mask[held rob_idx] is asserted in CALC or DONE, the next state SHALL be IDLE with out_valid 0; this has priority over out_ready.
REQ-022 in_rd == 0 SHALL still complete normally; suppressing the register-file write is the writeback logic's job.

Reset
REQ-023 While rst is 1, the unit SHALL be in IDLE with ready=1, out_valid=0, out_data=0, out_rd=0, out_rob_idx=0, counter=0 and all datapath registers 0, immediately and independent of clk.
REQ-024 Reset mid-CALC or mid-DONE SHALL discard the op; the first cycle after release SHALL be IDLE.

Configuration
REQ-025 Macro DIV_EARLY_OUT_EN defined: divide by zero, signed overflow, and |rs1| < |rs2| SHALL skip CALC and go from acceptance directly to DONE, so out_valid is asserted the cycle after acceptance.
REQ-026 Macro DIV_EARLY_OUT_EN undefined: every op SHALL take the full 32 CALC cycles; results SHALL be bit-identical to the defined case.

Structure
REQ-027 The shared package SHALL hold: the f3 encodings for DIV, DIVU, REM and REMU; the FU_DIV = 3'd2 fu_sel constant; and the div_state_t enum (IDLE, CALC, DONE).
REQ-028 The iteration datapath SHALL be one sub-module, div_core: a shift/subtract step plus partial-remainder and quotient registers. The FSM, sign handling and flush logic SHALL stay in div_unit.

Verification
REQ-029 DIV 0xFFFFFFF9 (-7) / 2 -> out_data 0xFFFFFFFD (-3), out_valid 33 cycles after acceptance (macro undefined).
REQ-030 REM -7 / 2 -> 0xFFFFFFFF; REMU 7 / 0 -> 7; DIVU 7 / 0 -> 0xFFFFFFFF.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; with DIV_EARLY_OUT_EN defined, out_valid the cycle after acceptance.
REQ-032 Accept rob_idx 5, then assert mispredict with flush_mask = 8'h20 at CALC cycle 10 -> IDLE next cycle, no out_valid, ready=1, a new op is accepted.
REQ-033 DIVU 100 / 7 with out_ready held 0 for 5 cycles in DONE -> out_data 14 held stable, ready=0 throughout, IDLE one cycle after out_ready=1.
REQ-034 Assert rst asynchronously mid-CALC -> outputs at reset values immediately; the next op after release completes correctly.
